// File: rtl/gcd_host_driver.sv
// ---------------------------------------------------------------------------
// gcd_host_driver
//
// Initiator for the GCD engine operand bus. An operand pair is taken from a
// valid/ready request port. The engine is then driven through its start /
// serial-data sequence: a start cycle, then A, then B. The driver waits for
// done, captures the result and offers it on a valid/ready response port.
// A watchdog turns a hung engine into a timeout response.
//
// Pairs with a zero operand never reach the engine, because such a pair
// would hang it. They are answered directly with A|B.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset (shared with the GCD engine)
//   req_valid    operand pair valid
//   req_ready    high only in IDLE; one transaction in flight at most
//   req_a/req_b  operands
//   gcd_start    start level to the GCD controller
//   gcd_data     serial operand bus to the GCD datapath
//   gcd_done     GCD controller done
//   gcd_result   GCD datapath result register
//   rsp_valid    response valid
//   rsp_ready    response consumed
//   rsp_gcd      result (0 on timeout)
//   rsp_timeout  1 = watchdog abort
//
// Every output is either a register or a decode of the state and operand
// registers, so no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module gcd_host_driver #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             gcd_start,
    output logic [WIDTH-1:0] gcd_data,
    input  logic             gcd_done,
    input  logic [WIDTH-1:0] gcd_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_gcd,
    output logic             rsp_timeout
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The watchdog stops at this value, so it never needs to wrap.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [WIDTH-1:0] rsp_gcd_q, rsp_gcd_d;
    logic             rsp_to_q, rsp_to_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            wd_q      <= '0;
            rsp_gcd_q <= '0;
            rsp_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            wd_q      <= wd_d;
            rsp_gcd_q <= rsp_gcd_d;
            rsp_to_q  <= rsp_to_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        wd_d      = wd_q;
        rsp_gcd_d = rsp_gcd_q;
        rsp_to_d  = rsp_to_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d = req_a;
                    b_d = req_b;
                    if ((req_a == '0) || (req_b == '0)) begin
                        // gcd(x,0) = x and gcd(0,0) = 0; the engine stays idle.
                        rsp_gcd_d = req_a | req_b;
                        rsp_to_d  = 1'b0;
                        state_d   = S_RESP;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START:  state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done is checked first, so it wins on the final watchdog cycle.
                if (gcd_done) begin
                    rsp_gcd_d = gcd_result;
                    rsp_to_d  = 1'b0;
                    state_d   = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    rsp_gcd_d = '0;
                    rsp_to_d  = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        gcd_start = (state_q == S_START) || (state_q == S_LOAD_A) ||
                    (state_q == S_LOAD_B) || (state_q == S_WAIT);
        case (state_q)
            S_LOAD_A: gcd_data = a_q;
            S_LOAD_B: gcd_data = b_q;
            default:  gcd_data = '0;
        endcase
    end

    assign rsp_gcd     = rsp_gcd_q;
    assign rsp_timeout = rsp_to_q;

endmodule
